// File: rtl/mult_add_fixp_pipe_if.sv
// -----------------------------------------------------------------------------
// mult_add_fixp_pipe_if
//
// Bundles the streaming handshake and data signals of mult_add_fixp_pipe.
//   ivalid / oready : upstream handshake (producer -> unit)
//   ovalid / iready : downstream handshake (unit -> consumer)
//   dataa / datab   : packed operands, pair k at [k*DATA_W +: DATA_W]
//   acc_en          : travels with the sample; 1 = add to previous result
//   result          : dot product / accumulated value
//
// Modports:
//   master : the side that produces operands and consumes results
//   slave  : the dot-product unit itself
// -----------------------------------------------------------------------------
interface mult_add_fixp_pipe_if #(
  parameter int DATA_W    = 8,
  parameter int NUM_PAIRS = 4,
  parameter int RESULT_W  = 32
);
  logic                          ivalid;
  logic                          oready;
  logic                          ovalid;
  logic                          iready;
  logic                          acc_en;
  logic [NUM_PAIRS*DATA_W-1:0]   dataa;
  logic [NUM_PAIRS*DATA_W-1:0]   datab;
  logic [RESULT_W-1:0]           result;

  modport master (
    output ivalid, iready, acc_en, dataa, datab,
    input  oready, ovalid, result
  );

  modport slave (
    input  ivalid, iready, acc_en, dataa, datab,
    output oready, ovalid, result
  );
endinterface

// File: rtl/mult_add_fixp_pipe.sv
// -----------------------------------------------------------------------------
// mult_add_fixp_pipe
//
// Pipelined fixed-point dot product of NUM_PAIRS operand pairs with optional
// running accumulation and optional output saturation.
//
//   S1 : register operands, acc_en and valid
//   S2 : register the NUM_PAIRS products (2*DATA_W bits each)
//   S3 : sum products, optionally add the previous result, clamp or wrap,
//        register into result / ovalid
//
// All three stages share one enable (en = ~ovalid | iready), so a stalled
// output freezes the whole pipe, bubbles included. Latency is 3 cycles,
// throughput one sample per cycle.
//
// Ports:
//   clock  : rising-edge clock
//   resetn : asynchronous active-low reset
//   bus    : slave side of mult_add_fixp_pipe_if (handshake, operands, result)
//
// Parameters:
//   DATA_W    operand width (2..18)
//   NUM_PAIRS number of multiply pairs (1..16)
//   RESULT_W  output width
//   SIGNED    1 = two's-complement operands, 0 = unsigned
//   SAT_EN    1 = clamp to the RESULT_W range, 0 = keep low RESULT_W bits
// -----------------------------------------------------------------------------
module mult_add_fixp_pipe #(
  parameter int DATA_W    = 8,
  parameter int NUM_PAIRS = 4,
  parameter int RESULT_W  = 32,
  parameter int SIGNED    = 1,
  parameter int SAT_EN    = 0
) (
  input logic                 clock,
  input logic                 resetn,
  mult_add_fixp_pipe_if.slave bus
);

  localparam int IN_W   = NUM_PAIRS * DATA_W;
  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = PROD_W + $clog2(NUM_PAIRS);
  localparam int MAX_W  = (SUM_W > RESULT_W) ? SUM_W : RESULT_W;
  // One bit for the accumulate carry, one more so an unsigned total is
  // still non-negative when viewed as two's complement.
  localparam int EXT_W  = MAX_W + 2;

  localparam logic SGN = (SIGNED != 0);

  localparam logic signed [EXT_W-1:0] C_ONE  = 1;
  localparam logic signed [EXT_W-1:0] C_SMAX = (C_ONE <<< (RESULT_W - 1)) - C_ONE;
  localparam logic signed [EXT_W-1:0] C_SMIN = -(C_ONE <<< (RESULT_W - 1));
  localparam logic signed [EXT_W-1:0] C_UMAX = (C_ONE <<< RESULT_W) - C_ONE;

  // ---------------------------------------------------------------------------
  // Arithmetic helpers
  // ---------------------------------------------------------------------------
  // Extending both operands to PROD_W and keeping the low PROD_W bits of the
  // product gives the exact signed or unsigned product in both modes.
  function automatic logic [PROD_W-1:0] mul_pair(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [PROD_W-1:0] ea;
    logic [PROD_W-1:0] eb;
    ea = {{DATA_W{SGN & a[DATA_W-1]}}, a};
    eb = {{DATA_W{SGN & b[DATA_W-1]}}, b};
    return ea * eb;
  endfunction

  function automatic logic [EXT_W-1:0] ext_prod(input logic [PROD_W-1:0] p);
    return {{(EXT_W - PROD_W){SGN & p[PROD_W-1]}}, p};
  endfunction

  function automatic logic [EXT_W-1:0] ext_res(input logic [RESULT_W-1:0] r);
    return {{(EXT_W - RESULT_W){SGN & r[RESULT_W-1]}}, r};
  endfunction

  // ---------------------------------------------------------------------------
  // Pipeline state
  // ---------------------------------------------------------------------------
  logic                              r_v1;
  logic                              r_v2;
  logic                              r_ovalid;
  logic                              r_acc1;
  logic                              r_acc2;
  logic [IN_W-1:0]                   r_a;
  logic [IN_W-1:0]                   r_b;
  logic [NUM_PAIRS-1:0][PROD_W-1:0]  r_prod;
  logic [RESULT_W-1:0]               r_result;

  logic                              w_en;
  logic [NUM_PAIRS-1:0][PROD_W-1:0]  w_prod;
  logic [EXT_W-1:0]                  w_sum;
  logic [EXT_W-1:0]                  w_total;
  logic [RESULT_W-1:0]               w_next;

  // The pipe can move whenever the output slot is empty or being drained.
  // oready depends combinationally on iready; that path is inherent to a
  // single common enable with no skid buffer.
  assign w_en       = ~r_ovalid | bus.iready;
  assign bus.oready = w_en;
  assign bus.ovalid = r_ovalid;
  assign bus.result = r_result;

  // ---------------------------------------------------------------------------
  // S1: capture operands
  // ---------------------------------------------------------------------------
  // NOTE: every data register, product array included, has an async reset so
  // the pipe comes out of reset in a fully known state; the accumulator
  // (r_result) in particular must start from zero.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_v1   <= 1'b0;
      r_acc1 <= 1'b0;
      r_a    <= '0;
      r_b    <= '0;
    end else if (w_en) begin
      // oready equals w_en here, so ivalid alone marks an accepted sample.
      r_v1   <= bus.ivalid;
      r_acc1 <= bus.acc_en;
      r_a    <= bus.dataa;
      r_b    <= bus.datab;
    end
  end

  // ---------------------------------------------------------------------------
  // S2: products
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int k = 0; k < NUM_PAIRS; k++) begin
      w_prod[k] = mul_pair(r_a[k*DATA_W +: DATA_W], r_b[k*DATA_W +: DATA_W]);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_v2   <= 1'b0;
      r_acc2 <= 1'b0;
      r_prod <= '0;
    end else if (w_en) begin
      r_v2   <= r_v1;
      r_acc2 <= r_acc1;
      r_prod <= w_prod;
    end
  end

  // ---------------------------------------------------------------------------
  // S3: reduce, accumulate, clamp or wrap
  // ---------------------------------------------------------------------------
  // The reduction is written as a loop; synthesis balances it into a tree.
  // EXT_W leaves headroom above SUM_W, so no partial sum can overflow.
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < NUM_PAIRS; k++) begin
      w_sum = w_sum + ext_prod(r_prod[k]);
    end
  end

  // The accumulator is the result register itself.
  assign w_total = r_acc2 ? (w_sum + ext_res(r_result)) : w_sum;

  always_comb begin
    w_next = w_total[RESULT_W-1:0];
    if (SAT_EN != 0) begin
      if (SGN) begin
        if ($signed(w_total) > C_SMAX) begin
          w_next = C_SMAX[RESULT_W-1:0];
        end else if ($signed(w_total) < C_SMIN) begin
          w_next = C_SMIN[RESULT_W-1:0];
        end
      end else begin
        if (w_total[EXT_W-1]) begin
          w_next = '0;
        end else if ($signed(w_total) > C_UMAX) begin
          w_next = C_UMAX[RESULT_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_ovalid <= 1'b0;
      r_result <= '0;
    end else if (w_en) begin
      r_ovalid <= r_v2;
      // Bubbles must not disturb the accumulator.
      if (r_v2) begin
        r_result <= w_next;
      end
    end
  end

endmodule

// File: tb/tb_mult_add_fixp_pipe.sv
// -----------------------------------------------------------------------------
// tb_mult_add_fixp_pipe
//
// Four instances share one stimulus:
//   d0 : defaults (signed, 32-bit result, wrap)
//   d1 : signed, 16-bit result, saturate
//   d2 : signed, 16-bit result, wrap
//   d3 : unsigned, 16-bit result, saturate
// Single-sample vectors come from a table; streaming, accumulation, stall and
// reset sequences are written out by hand against d0.
// -----------------------------------------------------------------------------
module tb_mult_add_fixp_pipe;

  logic        clock = 1'b0;
  logic        resetn;
  logic        ivalid;
  logic        iready;
  logic        acc_en;
  logic [31:0] dataa;
  logic [31:0] datab;

  always #5 clock = ~clock;

  mult_add_fixp_pipe_if #(.DATA_W(8), .NUM_PAIRS(4), .RESULT_W(32)) if0 ();
  mult_add_fixp_pipe_if #(.DATA_W(8), .NUM_PAIRS(4), .RESULT_W(16)) if1 ();
  mult_add_fixp_pipe_if #(.DATA_W(8), .NUM_PAIRS(4), .RESULT_W(16)) if2 ();
  mult_add_fixp_pipe_if #(.DATA_W(8), .NUM_PAIRS(4), .RESULT_W(16)) if3 ();

  assign if0.ivalid = ivalid;  assign if0.iready = iready;  assign if0.acc_en = acc_en;
  assign if0.dataa  = dataa;   assign if0.datab  = datab;
  assign if1.ivalid = ivalid;  assign if1.iready = iready;  assign if1.acc_en = acc_en;
  assign if1.dataa  = dataa;   assign if1.datab  = datab;
  assign if2.ivalid = ivalid;  assign if2.iready = iready;  assign if2.acc_en = acc_en;
  assign if2.dataa  = dataa;   assign if2.datab  = datab;
  assign if3.ivalid = ivalid;  assign if3.iready = iready;  assign if3.acc_en = acc_en;
  assign if3.dataa  = dataa;   assign if3.datab  = datab;

  mult_add_fixp_pipe #(.DATA_W(8), .NUM_PAIRS(4), .RESULT_W(32), .SIGNED(1), .SAT_EN(0))
    d0 (.clock(clock), .resetn(resetn), .bus(if0.slave));
  mult_add_fixp_pipe #(.DATA_W(8), .NUM_PAIRS(4), .RESULT_W(16), .SIGNED(1), .SAT_EN(1))
    d1 (.clock(clock), .resetn(resetn), .bus(if1.slave));
  mult_add_fixp_pipe #(.DATA_W(8), .NUM_PAIRS(4), .RESULT_W(16), .SIGNED(1), .SAT_EN(0))
    d2 (.clock(clock), .resetn(resetn), .bus(if2.slave));
  mult_add_fixp_pipe #(.DATA_W(8), .NUM_PAIRS(4), .RESULT_W(16), .SIGNED(0), .SAT_EN(1))
    d3 (.clock(clock), .resetn(resetn), .bus(if3.slave));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
  endtask

  // Single-sample vectors: operands and the expected result of each instance.
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e0;
    logic [15:0] e1;
    logic [15:0] e2;
    logic [15:0] e3;
  } vec_t;

  // Streaming items: vld = 0 inserts a one-cycle bubble; exp checked on d0.
  typedef struct {
    logic        vld;
    logic [31:0] a;
    logic [31:0] b;
    logic        acc;
    logic [31:0] exp;
  } item_t;

  vec_t  vecs[7];
  item_t items[$];
  logic [63:0] stall_mask;   // bit c set -> iready = 0 in stream cycle c

  task automatic push(input logic vld, input logic [31:0] a, input logic [31:0] b,
                      input logic acc, input logic [31:0] exp);
    item_t it;
    it.vld = vld; it.a = a; it.b = b; it.acc = acc; it.exp = exp;
    items.push_back(it);
  endtask

  // Drives items[] one per cycle (honouring oready), drains results with the
  // iready pattern from stall_mask, and compares each result in order.
  task automatic run_stream(input string tag, output int last_out);
    logic [31:0] expq[$];
    int  in_idx     = 0;
    int  out_idx    = 0;
    int  cyc        = 0;
    logic was_stall = 1'b0;
    last_out = -1;
    foreach (items[i]) if (items[i].vld) expq.push_back(items[i].exp);
    while (out_idx < expq.size() && cyc < 200) begin
      @(negedge clock);
      iready = (cyc < 64) ? !stall_mask[cyc] : 1'b1;
      if (in_idx < items.size()) begin
        ivalid = items[in_idx].vld;
        dataa  = items[in_idx].a;
        datab  = items[in_idx].b;
        acc_en = items[in_idx].acc;
      end else begin
        ivalid = 1'b0;
      end
      #1;
      if (was_stall) check({tag, " ovalid held"}, {31'd0, if0.ovalid}, 32'd1);
      was_stall = 1'b0;
      if (if0.ovalid && !iready) begin
        check({tag, " oready low in stall"}, {31'd0, if0.oready}, 32'd0);
        check({tag, " result held"}, if0.result, expq[out_idx]);
        was_stall = 1'b1;
      end
      if (in_idx < items.size() && (!items[in_idx].vld || if0.oready)) in_idx++;
      if (if0.ovalid && iready) begin
        check($sformatf("%s out%0d", tag, out_idx), if0.result, expq[out_idx]);
        out_idx++;
        last_out = cyc;
      end
      cyc++;
    end
    if (out_idx < expq.size()) check({tag, " timeout outputs"}, out_idx, expq.size());
    @(negedge clock);
    ivalid = 1'b0;
    iready = 1'b1;
    acc_en = 1'b0;
    repeat (3) @(negedge clock);
    check({tag, " no extra output"}, {31'd0, if0.ovalid}, 32'd0);
    items.delete();
    stall_mask = '0;
  endtask

  initial begin
    int last;

    //                  a             b             d0            d1        d2        d3
    vecs[0] = '{32'h04030201, 32'h08070605, 32'd70,       16'd70,   16'd70,   16'd70};
    vecs[1] = '{32'h80808080, 32'h80808080, 32'h00010000, 16'h7FFF, 16'h0000, 16'hFFFF};
    vecs[2] = '{32'h80808080, 32'h7F7F7F7F, 32'hFFFF0200, 16'h8000, 16'h0200, 16'hFE00};
    vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd4,        16'd4,    16'd4,    16'hFFFF};
    vecs[4] = '{32'h0500FF7F, 32'hFD09807F, 32'd16242,    16'd16242,16'd16242,16'd50034};
    vecs[5] = '{32'h7F7F7F7F, 32'h7F7F7F7F, 32'd64516,    16'h7FFF, 16'hFC04, 16'hFC04};
    vecs[6] = '{32'h00000000, 32'h00000000, 32'd0,        16'd0,    16'd0,    16'd0};

    stall_mask = '0;
    resetn = 1'b0;
    ivalid = 1'b0;
    iready = 1'b1;
    acc_en = 1'b0;
    dataa  = '0;
    datab  = '0;

    // Reset state
    #7;
    check("reset oready",  {31'd0, if0.oready}, 32'd1);
    check("reset ovalid",  {31'd0, if0.ovalid}, 32'd0);
    check("reset result",  if0.result, 32'd0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    #1;
    check("post-reset oready", {31'd0, if0.oready}, 32'd1);

    // Single samples: latency and arithmetic across all four configurations
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      ivalid = 1'b1;
      acc_en = 1'b0;
      dataa  = vecs[i].a;
      datab  = vecs[i].b;
      @(posedge clock);
      @(negedge clock);
      ivalid = 1'b0;
      @(negedge clock);
      check($sformatf("v%0d ovalid after 2", i), {31'd0, if0.ovalid}, 32'd0);
      @(negedge clock);
      check($sformatf("v%0d ovalid after 3", i), {31'd0, if0.ovalid}, 32'd1);
      check($sformatf("v%0d d0", i), if0.result, vecs[i].e0);
      check($sformatf("v%0d d1 sat16", i),  {16'd0, if1.result}, {16'd0, vecs[i].e1});
      check($sformatf("v%0d d2 wrap16", i), {16'd0, if2.result}, {16'd0, vecs[i].e2});
      check($sformatf("v%0d d3 usat16", i), {16'd0, if3.result}, {16'd0, vecs[i].e3});
    end

    // Back-to-back, one per cycle, in order
    push(1'b1, 32'h80808080, 32'h80808080, 1'b0, 32'h00010000);
    push(1'b1, 32'h80808080, 32'h7F7F7F7F, 1'b0, 32'hFFFF0200);
    push(1'b1, 32'h04030201, 32'h08070605, 1'b0, 32'd70);
    run_stream("b2b", last);
    check("b2b last output cycle", last, 32'd5);

    // Accumulation
    push(1'b1, 32'h04030201, 32'h08070605, 1'b0, 32'd70);
    push(1'b1, 32'h04030201, 32'h08070605, 1'b1, 32'd140);
    push(1'b1, 32'h04030201, 32'h08070605, 1'b1, 32'd210);
    run_stream("acc", last);

    // Accumulation with a bubble between the second and third sample
    push(1'b1, 32'h04030201, 32'h08070605, 1'b0, 32'd70);
    push(1'b1, 32'h04030201, 32'h08070605, 1'b1, 32'd140);
    push(1'b0, 32'h00000000, 32'h00000000, 1'b0, 32'd0);
    push(1'b1, 32'h04030201, 32'h08070605, 1'b1, 32'd210);
    run_stream("acc bubble", last);

    // Six samples, downstream stalls for 5 cycles once the pipe is full
    for (int k = 1; k <= 6; k++) begin
      push(1'b1, 32'h01010101 * k, 32'h01010101, 1'b0, 32'(4 * k));
    end
    stall_mask = 64'h1F0;
    run_stream("stall", last);
    check("stall last output cycle", last, 32'd13);

    // Asynchronous reset with three samples in flight
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      ivalid = 1'b1;
      acc_en = 1'b0;
      dataa  = 32'h04030201;
      datab  = 32'h08070605;
    end
    @(negedge clock);
    ivalid = 1'b0;
    #1;
    check("pre-reset ovalid", {31'd0, if0.ovalid}, 32'd1);
    #1;
    resetn = 1'b0;
    #1;
    check("mid reset ovalid", {31'd0, if0.ovalid}, 32'd0);
    check("mid reset result", if0.result, 32'd0);
    check("mid reset oready", {31'd0, if0.oready}, 32'd1);
    @(negedge clock);
    resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check($sformatf("after reset idle%0d", k), {31'd0, if0.ovalid}, 32'd0);
    end
    push(1'b1, 32'h04030201, 32'h08070605, 1'b1, 32'd70);
    run_stream("acc after reset", last);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
